// File: rtl/systolic_mm_core.sv
// systolic_mm_core
//   Output-stationary NxN systolic matrix multiplier.
//   Streams in A then B (each row-major, DW bits per element), runs 3N-2
//   compute cycles through an NxN grid of multiply-accumulate cells, then
//   streams out C = A*B (optionally added to the previous C) row-major.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : input element handshake, in_data carries the element
//   signed_mode     : two's complement operands when 1 (sampled at run start)
//   acc_en          : accumulate onto previous C when 1 (sampled at run start)
//   out_valid/ready : result handshake, out_data carries one C element
//   busy            : core is not idle
//   done            : one-cycle pulse after the last C element is taken
module systolic_mm_core #(
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             signed_mode,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             done
);

  localparam int NN = N * N;
  localparam int LW = $clog2(2 * NN);
  localparam int TW = $clog2(3 * N);
  localparam int OW = $clog2(NN);

  localparam logic [LW-1:0] LOAD_LAST = LW'(2 * NN - 1);
  localparam logic [TW-1:0] COMP_LAST = TW'(3 * N - 3);
  localparam logic [OW-1:0] OUT_LAST  = OW'(NN - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   load_cnt_q, load_cnt_d;
  logic [TW-1:0]   cyc_q, cyc_d;
  logic [OW-1:0]   out_idx_q, out_idx_d;
  logic            mode_q, mode_d;
  logic            acc_en_q, acc_en_d;
  logic            done_q, done_d;
  logic            ready_q;

  logic            in_hs, out_hs, compute_act, first_cyc;

  logic [DW-1:0]    a_mem [NN];
  logic [DW-1:0]    b_mem [NN];
  logic [DW-1:0]    west  [N];
  logic [DW-1:0]    north [N];
  logic [DW-1:0]    a_pipe [N*(N-1)];
  logic [DW-1:0]    b_pipe [N*(N-1)];
  logic [ACC_W-1:0] acc_flat [NN];

  // ready_q keeps in_ready low until the first edge after reset releases
  assign in_ready    = ready_q & ((state_q == S_IDLE) | (state_q == S_LOAD));
  assign in_hs       = in_valid & in_ready;
  assign out_valid   = (state_q == S_OUT);
  assign out_hs      = out_valid & out_ready;
  assign out_data    = out_valid ? acc_flat[out_idx_q] : '0;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign compute_act = (state_q == S_COMPUTE);
  assign first_cyc   = (cyc_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      cyc_q      <= '0;
      out_idx_q  <= '0;
      mode_q     <= 1'b0;
      acc_en_q   <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      cyc_q      <= cyc_d;
      out_idx_q  <= out_idx_d;
      mode_q     <= mode_d;
      acc_en_q   <= acc_en_d;
      done_q     <= done_d;
      ready_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    cyc_d      = cyc_q;
    out_idx_d  = out_idx_q;
    mode_d     = mode_q;
    acc_en_d   = acc_en_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_hs) begin
          state_d    = S_LOAD;
          load_cnt_d = LW'(1);
          mode_d     = signed_mode;
          acc_en_d   = acc_en;
        end
      end
      S_LOAD: begin
        if (in_hs) begin
          if (load_cnt_q == LOAD_LAST) begin
            state_d    = S_COMPUTE;
            load_cnt_d = '0;
            cyc_d      = '0;
          end else begin
            load_cnt_d = load_cnt_q + LW'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (cyc_q == COMP_LAST) begin
          state_d   = S_OUT;
          cyc_d     = '0;
          out_idx_d = '0;
        end else begin
          cyc_d = cyc_q + TW'(1);
        end
      end
      S_OUT: begin
        if (out_hs) begin
          if (out_idx_q == OUT_LAST) begin
            state_d   = S_IDLE;
            out_idx_d = '0;
            done_d    = 1'b1;
          end else begin
            out_idx_d = out_idx_q + OW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  genvar gi, gj;

  // Operand store: element number load_cnt_q lands in A for 0..NN-1, B after
  for (gi = 0; gi < NN; gi++) begin : g_mem
    logic [DW-1:0] a_q, b_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
      end else if (in_hs) begin
        if (load_cnt_q == LW'(gi))      a_q <= in_data;
        if (load_cnt_q == LW'(NN + gi)) b_q <= in_data;
      end
    end
    assign a_mem[gi] = a_q;
    assign b_mem[gi] = b_q;
  end

  // Skewed edge feeds: row i of A (column j of B) starts i (j) cycles late;
  // anything outside the N-cycle window is a zero operand.
  for (gi = 0; gi < N; gi++) begin : g_edge
    logic [DW-1:0] w_v, n_v;
    always_comb begin
      w_v = '0;
      n_v = '0;
      for (int k = 0; k < N; k++) begin
        if (cyc_q == TW'(gi + k)) begin
          w_v = a_mem[gi*N + k];
          n_v = b_mem[k*N + gi];
        end
      end
    end
    assign west[gi]  = w_v;
    assign north[gi] = n_v;
  end

  for (gi = 0; gi < N; gi++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      logic [DW-1:0]        a_in, b_in;
      logic signed [DW:0]   a_s, b_s;
      logic signed [2*DW+1:0] p_s;
      logic [ACC_W-1:0]     term, acc_q, acc_d;

      if (gj == 0) begin : g_a_edge
        assign a_in = west[gi];
      end else begin : g_a_nbr
        assign a_in = a_pipe[gi*(N-1) + gj - 1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in = north[gj];
      end else begin : g_b_nbr
        assign b_in = b_pipe[(gi-1)*N + gj];
      end

      // One extra top bit makes a single signed multiplier cover both modes
      assign a_s = {mode_q & a_in[DW-1], a_in};
      assign b_s = {mode_q & b_in[DW-1], b_in};
      assign p_s = a_s * b_s;
      if (ACC_W > 2*DW + 2) begin : g_ext
        assign term = {{(ACC_W-2*DW-2){p_s[2*DW+1]}}, p_s};
      end else begin : g_trunc
        assign term = p_s[ACC_W-1:0];
      end

      assign acc_d = ((first_cyc & ~acc_en_q) ? '0 : acc_q) + term;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)              acc_q <= '0;
        else if (compute_act) acc_q <= acc_d;
      end
      assign acc_flat[gi*N + gj] = acc_q;

      // Pass-through registers are flushed outside COMPUTE so each run starts clean
      if (gj < N-1) begin : g_pass_a
        logic [DW-1:0] a_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) a_q <= '0;
          else     a_q <= compute_act ? a_in : '0;
        end
        assign a_pipe[gi*(N-1) + gj] = a_q;
      end
      if (gi < N-1) begin : g_pass_b
        logic [DW-1:0] b_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) b_q <= '0;
          else     b_q <= compute_act ? b_in : '0;
        end
        assign b_pipe[gi*N + gj] = b_q;
      end
    end
  end

endmodule

// File: doc/systolic_mm_core.md
SYSTOLIC_MM_CORE -- requirements
Module: systolic_mm_core

Interface
REQ-001 SHALL have parameter N, default 2, meaning array dimension (NxN processing elements, NxN matrices); legal range 2..8.
REQ-002 SHALL have parameter DW, default 8, meaning input element width in bits.
REQ-003 SHALL have parameter ACC_W, default 18, meaning accumulator and result width in bits; must be >= 2*DW.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, meaning in_data holds a valid element.
REQ-007 SHALL have port in_ready, output, 1, meaning the core accepts an element this cycle.
REQ-008 SHALL have port in_data, input, DW, meaning the matrix element (A then B, each row-major).
REQ-009 SHALL have port signed_mode, input, 1, meaning operands are two's complement when 1 and unsigned when 0.
REQ-010 SHALL have port acc_en, input, 1, meaning add the new product to the previous results instead of clearing first.
REQ-011 SHALL have port out_valid, output, 1, meaning out_data holds a valid C element.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-013 SHALL have port out_data, output, ACC_W, meaning the C element, row-major.
REQ-014 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-015 SHALL have port done, output, 1, meaning a one-cycle pulse after the last C element is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, COMPUTE and OUT.
REQ-017 SHALL assert in_ready only in IDLE and LOAD; a handshake is in_valid and in_ready high in the same cycle.
REQ-018 SHALL, on the first handshake in IDLE, go to LOAD, store the element as A[0][0], and sample signed_mode and acc_en into registers held for the whole run.
REQ-019 SHALL load exactly 2*N*N elements: A[0][0]..A[N-1][N-1], then B[0][0]..B[N-1][N-1]; gaps with in_valid low are allowed and do not advance the count.
REQ-020 SHALL enter COMPUTE in the cycle after the final load handshake and stay there exactly 3N-2 cycles.
REQ-021 SHALL, at COMPUTE entry, clear all accumulators when the sampled acc_en is 0 and keep them when it is 1.
REQ-022 SHALL feed row i of A into the west edge delayed by i cycles and column j of B into the north edge delayed by j cycles; each PE passes a east and b south through one register each cycle.
REQ-023 SHALL have PE(i,j) add a*b in compute cycle i+j+k for k = 0..N-1, and insert zero operands outside the valid skew window.
REQ-024 SHALL form the product at full 2*DW width, signed or unsigned according to the sampled mode, and sign- or zero-extend it to ACC_W.
REQ-025 SHALL wrap accumulation modulo 2^ACC_W, with no saturation.
REQ-026 SHALL, in OUT, present C row-major with out_valid high, advancing on each out_valid and out_ready handshake.
REQ-027 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-028 SHALL assert out_valid first 3N-1 cycles after the final load handshake, which is 5 cycles for N=2.
REQ-029 SHALL, after the N*N-th output handshake, pulse done for one cycle and return to IDLE, with the accumulators retained for a later acc_en run.
REQ-030 SHALL ignore in_valid outside IDLE and LOAD, and ignore out_ready outside OUT.
REQ-031 SHALL sustain one output per cycle when out_ready is held high.

Reset
REQ-032 SHALL, on rst high, immediately set the FSM to IDLE, clear all counters, accumulators and pipeline registers, and force in_ready=0, out_valid=0, out_data=0, busy=0 and done=0.
REQ-033 SHALL discard any partial load, computation or output on reset, and drive in_ready=1 in the first clock edge after rst falls.

Verification
REQ-034 SHALL cover the unsigned case: N=2, A=[1,2,3,4], B=[5,6,7,8], acc_en=0 -> C=19,22,43,50; out_valid first 5 cycles after the last load; done pulses once.
REQ-035 SHALL cover the signed case: A=[0xFF,0,0,0xFF] (-I), B=[5,6,7,8] -> C=-5,-6,-7,-8 (0x3FFFB,0x3FFFA,0x3FFF9,0x3FFF8).
REQ-036 SHALL cover accumulation: the unsigned case run twice, the second run with acc_en=1 -> C=38,44,86,100.
REQ-037 SHALL cover backpressure: out_ready low for 3 cycles on element 1 -> out_data holds 22; no element is lost or duplicated; in_ready stays 0.
REQ-038 SHALL cover reset in COMPUTE: assert rst mid-COMPUTE -> all outputs 0 at once; a fresh run with acc_en=1 then yields 19,22,43,50.
REQ-039 SHALL cover the full-scale unsigned case: all elements 255 -> each C = 130050, with no wrap.
